mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_prio.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } gnt_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MASK_W     = DATA_W_DEF / 8;

    function automatic int unsigned mask_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data ports, with the starvation counter
// that forces a fetch grant after STARVE_MAX back-to-back data wins.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_if_gnt,
    output logic o_d_gnt,
    output gnt_e o_gnt
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          starved;

    always_comb begin
        starved      = (starve_cnt_q == CW'(STARVE_MAX));
        o_if_gnt     = 1'b0;
        o_d_gnt      = 1'b0;
        starve_cnt_d = starve_cnt_q;

        if (i_idle) begin
            if (i_d_req && !(i_if_req && starved)) begin
                o_d_gnt = 1'b1;
            end else if (i_if_req) begin
                o_if_gnt = 1'b1;
            end
        end

        o_gnt = o_d_gnt ? GNT_D : GNT_IF;

        // Only a data win over a waiting fetch counts toward starvation.
        if (o_if_gnt) begin
            starve_cnt_d = '0;
        end else if (o_d_gnt) begin
            if (!i_if_req) begin
                starve_cnt_d = '0;
            end else if (!starved) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing a fixed-latency unified memory between
// the instruction-fetch and load/store ports of a core.
//
//   state | meaning
//   IDLE  | ready to accept one request from either port
//   ISSUE | memory strobe driven from the latched request
//   WAIT  | MEM_LAT cycles of memory latency; read data captured in the last
//   RESP  | valid pulse to the granted port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_ready,
    output logic                o_if_valid,
    output logic [DATA_W-1:0]   o_if_rdata,

    input  logic                i_d_req,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic                i_d_wen,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_mask,
    output logic                o_d_ready,
    output logic                o_d_valid,
    output logic [DATA_W-1:0]   o_d_rdata,

    output logic                o_mem_req,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_mask,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int unsigned MW = mask_width(DATA_W);
    localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e          state_q,    state_d;
    gnt_e            gnt_q,      gnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic            wen_q,      wen_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [MW-1:0]   mask_q,     mask_d;
    logic [LW-1:0]   lat_q,      lat_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

    logic if_gnt;
    logic d_gnt;
    gnt_e gnt;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_idle   (state_q == IDLE),
        .i_if_req (i_if_req),
        .i_d_req  (i_d_req),
        .o_if_gnt (if_gnt),
        .o_d_gnt  (d_gnt),
        .o_gnt    (gnt)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        lat_d      = lat_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    state_d = ISSUE;
                    gnt_d   = gnt;
                    addr_d  = i_d_addr;
                    wen_d   = i_d_wen;
                    wdata_d = i_d_wdata;
                    mask_d  = i_d_mask;
                end else if (if_gnt) begin
                    state_d = ISSUE;
                    gnt_d   = gnt;
                    addr_d  = i_if_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    mask_d  = '1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LW'(MEM_LAT - 1);
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                    // Stores report zero data so a stale bus value never leaks out.
                    if (gnt_q == GNT_D) begin
                        d_rdata_d = wen_q ? '0 : i_mem_rdata;
                    end else begin
                        if_rdata_d = i_mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            mask_q     <= '0;
            lat_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            lat_q      <= lat_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        o_if_ready  = if_gnt;
        o_d_ready   = d_gnt;
        o_mem_req   = (state_q == ISSUE);
        o_mem_addr  = o_mem_req ? addr_q  : '0;
        o_mem_wen   = o_mem_req ? wen_q   : 1'b0;
        o_mem_wdata = o_mem_req ? wdata_q : '0;
        o_mem_mask  = o_mem_req ? mask_q  : '0;
        o_if_valid  = (state_q == RESP) && (gnt_q == GNT_IF);
        o_d_valid   = (state_q == RESP) && (gnt_q == GNT_D);
        o_if_rdata  = if_rdata_q;
        o_d_rdata   = d_rdata_q;
    end

endmodule
